// File: rtl/alu_amm_pkg.sv
// alu_amm_pkg: shared widths, AMM response codes and arbiter state encoding
package alu_amm_pkg;
  localparam int ALU_AMM_ADDR_W = 8;
  localparam int ALU_AMM_DATA_W = 8;
  localparam logic [1:0] AMM_RSP_OKAY = 2'b00;
  localparam logic [1:0] AMM_RSP_SLVERR = 2'b10;
  localparam logic [1:0] AMM_RSP_DECODEERR = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin selector, tie goes to the requester other than last_grant
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  always_comb begin
    gnt_valid = |req;
    gnt_idx = &req ? !last_grant : req[1];
  end
endmodule

// File: rtl/alu_amm_arbiter.sv
// alu_amm_arbiter: two-requester round-robin AMM read arbiter with committed grants and a BUSY timeout
module alu_amm_arbiter
  import alu_amm_pkg::*;
#(
  parameter int ADDR_W = ALU_AMM_ADDR_W,
  parameter int DATA_W = ALU_AMM_DATA_W,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_read,
  input  logic [ADDR_W-1:0] rq0_address,
  output logic [DATA_W-1:0] rq0_readdata,
  output logic              rq0_waitrequest,
  output logic [1:0]        rq0_response,
  input  logic              rq1_read,
  input  logic [ADDR_W-1:0] rq1_address,
  output logic [DATA_W-1:0] rq1_readdata,
  output logic              rq1_waitrequest,
  output logic [1:0]        rq1_response,
  output logic              amm_read,
  output logic [ADDR_W-1:0] amm_address,
  input  logic [DATA_W-1:0] amm_readdata,
  input  logic              amm_waitrequest,
  input  logic [1:0]        amm_response
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  arb_state_t state;
  logic win, last_grant, gnt_valid, gnt_idx, gnt0, gnt1;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0] rsp_q;
  logic [7:0] cnt;
  rr_arbiter2 u_rr (
    .req        ({rq1_read, rq0_read}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      last_grant <= 1'b1;
      win <= 1'b0;
      cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      rsp_q <= AMM_RSP_OKAY;
    end else begin
      case (state)
        ST_IDLE: if (gnt_valid) begin
          win <= gnt_idx;
          addr_q <= gnt_idx ? rq1_address : rq0_address;
          cnt <= '0;
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          cnt <= cnt + 8'd1;
          if (!amm_waitrequest) begin
            data_q <= amm_readdata;
            rsp_q <= amm_response;
            state <= ST_RESP;
          end else if (cnt == TO_LAST) begin
            data_q <= '0;
            rsp_q <= AMM_RSP_SLVERR;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant <= win;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  always_comb begin
    gnt0 = state == ST_RESP && !win;
    gnt1 = state == ST_RESP && win;
    amm_read = state == ST_BUSY;
    amm_address = addr_q;
    rq0_waitrequest = !gnt0;
    rq1_waitrequest = !gnt1;
    rq0_readdata = gnt0 ? data_q : '0;
    rq1_readdata = gnt1 ? data_q : '0;
    rq0_response = gnt0 ? rsp_q : AMM_RSP_OKAY;
    rq1_response = gnt1 ? rsp_q : AMM_RSP_OKAY;
  end
endmodule

// File: tb/tb_alu_amm_arbiter.sv
// tb_alu_amm_arbiter: directed plus random checks of the arbiter against a transaction-level model and a register-file slave
module tb_alu_amm_arbiter;
  localparam int T = 8;
  logic clk = 0, rst = 1;
  logic rq0_read = 0, rq1_read = 0;
  logic [7:0] rq0_address = 0, rq1_address = 0;
  logic [7:0] rq0_readdata, rq1_readdata, amm_address, amm_readdata;
  logic rq0_waitrequest, rq1_waitrequest, amm_read, amm_waitrequest;
  logic [1:0] rq0_response, rq1_response, amm_response;
  logic stall = 0;
  logic [7:0] scnt = 0;
  logic exp_last = 1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_amm_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .rq0_read(rq0_read), .rq0_address(rq0_address), .rq0_readdata(rq0_readdata),
    .rq0_waitrequest(rq0_waitrequest), .rq0_response(rq0_response),
    .rq1_read(rq1_read), .rq1_address(rq1_address), .rq1_readdata(rq1_readdata),
    .rq1_waitrequest(rq1_waitrequest), .rq1_response(rq1_response),
    .amm_read(amm_read), .amm_address(amm_address), .amm_readdata(amm_readdata),
    .amm_waitrequest(amm_waitrequest), .amm_response(amm_response)
  );
  function automatic logic [7:0] rf_data(input logic [7:0] a);
    case (a)
      8'h00: return 8'd103;
      8'h30: return 8'd124;
      8'hA0: return 8'd2;
      8'h0F: return 8'd70;
      8'h7F: return 8'd92;
      default: return a ^ 8'h5A;
    endcase
  endfunction
  function automatic logic unmapped(input logic [7:0] a);
    return a[7:4] == 4'h2;
  endfunction
  always @(posedge clk) scnt <= amm_read ? scnt + 8'd1 : 8'd0;
  always_comb begin
    amm_waitrequest = stall || !(amm_read && scnt == 8'd3);
    amm_response = unmapped(amm_address) ? 2'b11 : 2'b00;
    amm_readdata = (amm_waitrequest || unmapped(amm_address)) ? 8'd0 : rf_data(amm_address);
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run(input logic r0, input logic [7:0] a0, input logic r1, input logic [7:0] a1,
                     input logic st, input logic chg);
    logic w, idle;
    logic [7:0] ea, ed;
    logic [1:0] er;
    int lat, k;
    idle = !amm_read && rq0_waitrequest && rq1_waitrequest;
    w = (r0 && r1) ? !exp_last : r1;
    ea = w ? a1 : a0;
    lat = st ? T + 1 : 5;
    ed = (st || unmapped(ea)) ? 8'd0 : rf_data(ea);
    er = st ? 2'b10 : (unmapped(ea) ? 2'b11 : 2'b00);
    rq0_read = r0;
    rq0_address = a0;
    rq1_read = r1;
    rq1_address = a1;
    stall = st;
    k = 0;
    do begin
      tick();
      k++;
    end while (!amm_read && k < 3);
    check("start", 32'(k), idle ? 32'd1 : 32'd2);
    for (int i = 1; i < lat; i++) begin
      if (chg && i == 2) rq0_address = a0 ^ 8'h0F;
      check("busy", {22'd0, amm_read, amm_address, rq0_waitrequest, rq1_waitrequest}, {22'd0, 1'b1, ea, 2'b11});
      tick();
    end
    check("resp_hs", {29'd0, amm_read, rq0_waitrequest, rq1_waitrequest}, {29'd0, 1'b0, w, !w});
    check("resp_data", 32'(w ? rq1_readdata : rq0_readdata), 32'(ed));
    check("resp_code", 32'(w ? rq1_response : rq0_response), 32'(er));
    check("loser_zero", {22'd0, w ? rq0_readdata : rq1_readdata, w ? rq0_response : rq1_response}, 32'd0);
    if (w) rq1_read = 0;
    else rq0_read = 0;
    stall = 0;
    exp_last = w;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic r0, r1;
    logic [7:0] a0, a1;
    int k;
    @(negedge clk);
    tick();
    tick();
    check("rst_out", {10'd0, amm_read, amm_address, rq0_waitrequest, rq1_waitrequest, rq0_readdata, rq1_readdata},
          {10'd0, 1'b0, 8'd0, 2'b11, 16'd0});
    check("rst_rsp", {28'd0, rq0_response, rq1_response}, 32'd0);
    rst = 0;
    run(1, 8'h00, 0, 8'h00, 0, 0);
    run(0, 8'h00, 1, 8'h20, 0, 0);
    run(1, 8'h30, 1, 8'hA0, 0, 0);
    check("alt1", 32'(exp_last), 32'd0);
    run(0, 8'h30, 1, 8'hA0, 0, 0);
    check("alt2", 32'(exp_last), 32'd1);
    run(1, 8'h30, 1, 8'hA0, 0, 0);
    check("alt3", 32'(exp_last), 32'd0);
    run(0, 8'h30, 1, 8'hA0, 0, 0);
    run(1, 8'h44, 0, 8'h00, 1, 0);
    run(1, 8'h0F, 0, 8'h00, 0, 0);
    rq0_read = 1;
    rq0_address = 8'h00;
    k = 0;
    do begin
      tick();
      k++;
    end while (!amm_read && k < 4);
    check("rst_busy_seen", 32'(amm_read), 32'd1);
    tick();
    rst = 1;
    rq0_read = 0;
    tick();
    check("rst_abort", {29'd0, amm_read, rq0_waitrequest, rq1_waitrequest}, {29'd0, 3'b011});
    rst = 0;
    exp_last = 1;
    run(0, 8'h00, 1, 8'h7F, 0, 0);
    run(1, 8'h0F, 0, 8'h00, 0, 1);
    for (int n = 0; n < 25; n++) begin
      r0 = rq0_read ? 1'b1 : 1'($urandom);
      r1 = rq1_read ? 1'b1 : 1'($urandom);
      if (!r0 && !r1) r0 = 1;
      a0 = rq0_read ? rq0_address : 8'($urandom);
      a1 = rq1_read ? rq1_address : 8'($urandom);
      run(r0, a0, r1, a1, $urandom_range(0, 5) == 0, 0);
    end
    while (rq0_read || rq1_read) run(rq0_read, rq0_address, rq1_read, rq1_address, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
